// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS core: opcodes, functs,
// FSM state numbering (visible on the debug port) and ALU control codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_HALT      = 4'd15
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, $0 hardwired to zero.
module mips_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != 5'd0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == 5'd0) ? '0 : regs_q[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/mips_multicycle.sv
// Multicycle MIPS core: one shared ALU and one req/ready memory port stepped
// through fetch/decode/execute/memory/writeback by a single FSM.
module mips_multicycle
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          RET_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic [31:0]      pc,
  output logic [3:0]       state,
  output logic             halted,
  output logic [RET_W-1:0] retired
);

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
  logic [31:0]        a_q, a_d, b_q, b_d, alu_q, alu_d;
  logic [RET_W-1:0]   ret_q, ret_d;

  logic               rf_we;
  logic [4:0]         rf_wa;
  logic [31:0]        rf_wd, rf_rd1, rf_rd2;

  logic [5:0]         op, funct;
  logic [4:0]         rs, rt, rd;
  logic signed [31:0] imm_sx;
  logic               funct_ok;
  alu_op_t            alu_ctrl;

  assign op     = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign imm_sx = {{16{ir_q[15]}}, ir_q[15:0]};

  function automatic logic [31:0] alu_eval(input alu_op_t ctl, input logic [31:0] x,
                                           input logic [31:0] y);
    logic signed [31:0] xs, ys;
    xs = x;
    ys = y;
    case (ctl)
      ALU_SUB: return x - y;
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_SLT: return {31'd0, (xs < ys)};
      default: return x + y;
    endcase
  endfunction

  always_comb begin
    funct_ok = 1'b1;
    alu_ctrl = ALU_ADD;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  mips_regfile u_rf (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (rs),
    .ra2_i (rt),
    .rd1_o (rf_rd1),
    .rd2_o (rf_rd2),
    .we_i  (rf_we),
    .wa_i  (rf_wa),
    .wd_i  (rf_wd)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
    ret_d   = ret_q;
    rf_we   = 1'b0;
    rf_wa   = rt;
    rf_wd   = alu_q;
    unique case (state_q)
      S_FETCH: if (mem_ready) begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + 32'd4;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d   = rf_rd1;
        b_d   = rf_rd2;
        // Branch target computed speculatively from the already-incremented PC.
        alu_d = pc_q + {imm_sx[29:0], 2'b00};
        case (op)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = funct_ok ? S_EXECUTE : S_HALT;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEM_ADDR: begin
        alu_d   = a_q + imm_sx;
        state_d = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: if (mem_ready) begin
        mdr_d   = mem_rdata;
        state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        rf_we   = 1'b1;
        rf_wd   = mdr_q;
        ret_d   = ret_q + 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_WRITE: if (mem_ready) begin
        ret_d   = ret_q + 1'b1;
        state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alu_d   = alu_eval(alu_ctrl, a_q, b_q);
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        rf_we   = 1'b1;
        rf_wa   = rd;
        ret_d   = ret_q + 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        if (a_q == b_q) pc_d = alu_q;
        ret_d   = ret_q + 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
        ret_d   = ret_q + 1'b1;
        state_d = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_d   = a_q + imm_sx;
        state_d = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        rf_we   = 1'b1;
        ret_d   = ret_q + 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      mdr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      ret_q   <= ret_d;
    end
  end

  // Request is a pure function of state; rst gates it so an abandoned
  // request drops the instant reset is applied.
  assign mem_req   = !rst && ((state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                              (state_q == S_MEM_WRITE));
  assign mem_we    = (state_q == S_MEM_WRITE);
  assign mem_addr  = (state_q == S_FETCH) ? {pc_q[31:2], 2'b00} : {alu_q[31:2], 2'b00};
  assign mem_wdata = b_q;
  assign pc        = pc_q;
  assign state     = state_q;
  assign halted    = (state_q == S_HALT);
  assign retired   = ret_q;

endmodule

// File: doc/mips_multicycle.md
# mips_multicycle

Multicycle MIPS core: the next-generation replacement for the single-cycle `cpu` top. A state machine shares one ALU and one memory port across fetch, decode, execute, memory and writeback steps. The unified memory port carries a req/ready handshake, so wait-state memories are tolerated. Adds halt-on-illegal-opcode and a retired-instruction counter for bring-up and board debug.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `RET_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_req` out 1: memory request valid.
- `mem_we` out 1: 1 = store, 0 = load or fetch. Meaningful only while `mem_req`=1.
- `mem_addr` out 32: byte address, always word-aligned.
- `mem_wdata` out 32: store data.
- `mem_rdata` in 32: read data, valid in the cycle `mem_req && mem_ready`.
- `mem_ready` in 1: completes the current request. May be tied high for zero-wait memory.
- `pc` out 32: current PC.
- `state` out 4: current FSM state, for debug.
- `halted` out 1: core stopped on an illegal opcode.
- `retired` out RET_W: count of completed instructions. Wraps modulo 2^RET_W.

## Operation
- Supported instructions: R-type add(20), sub(22), and(24), or(25), slt(2A); lw(23); sw(2B); beq(04); addi(08); j(02). Codes are hex.
- Any other opcode, or an R-type with another funct, enters HALT.
- Internal registers:
  - IR, MDR, A, B, ALUOut.
  - 32x32 register file. $0 reads 0 and ignores writes.
- FSM states and transitions:
  - FETCH (0): `mem_req`=1, `mem_we`=0, `mem_addr`=PC. Holds until `mem_ready`, then IR<=rdata, PC<=PC+4, next DECODE.
  - DECODE (1): A<=rf[rs], B<=rf[rt], ALUOut<=PC+(sext(imm)<<2). Next state by opcode:
    - lw/sw -> MEM_ADDR
    - R -> EXECUTE
    - beq -> BRANCH
    - j -> JUMP
    - addi -> ADDI_EX
    - else -> HALT
  - MEM_ADDR (2): ALUOut<=A+sext(imm). Next MEM_READ (lw) or MEM_WRITE (sw).
  - MEM_READ (3): request with addr=ALUOut. On ready, MDR<=rdata, next MEM_WB.
  - MEM_WB (4): rf[rt]<=MDR. Retire. Next FETCH.
  - MEM_WRITE (5): request with `mem_we`=1, addr=ALUOut, wdata=B. On ready, retire and go to FETCH.
  - EXECUTE (6): ALUOut<=A op B. Next ALU_WB.
  - ALU_WB (7): rf[rd]<=ALUOut. Retire. Next FETCH.
  - BRANCH (8): if A==B, PC<=ALUOut. Retire. Next FETCH.
  - JUMP (9): PC<={PC[31:28], IR[25:0], 2'b00}. Retire. Next FETCH.
  - ADDI_EX (10): ALUOut<=A+sext(imm). Next ADDI_WB.
  - ADDI_WB (11): rf[rt]<=ALUOut. Retire. Next FETCH.
  - HALT (15): `halted`=1, no requests issued. Leaves only on reset.
- Arithmetic:
  - All operations are 32-bit two's complement; overflow is ignored (no trap).
  - slt is a signed compare and writes 0 or 1.
  - Branch offset is taken from the already-incremented PC.

## Timing
- Reset values: PC=RESET_PC, state=FETCH, all registers and IR/MDR/A/B/ALUOut = 0, `retired`=0, `halted`=0, `mem_req`=0.
- First request is issued in the first cycle after `rst` deasserts.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are decoded from registered state only; none depend combinationally on `mem_ready`.
- Request fields are held stable until the cycle in which `mem_ready`=1.
- The core holds at most one outstanding request at a time.
- Cycles per instruction with zero-wait memory:
  - lw 5, sw 4, R 4, addi 4, beq 3, j 3.
  - Each wait cycle adds 1 in FETCH, MEM_READ or MEM_WRITE.
- `retired` increments on the clock edge that leaves the retiring state.
- Register file:
  - Write is synchronous.
  - Read is asynchronous, but results are consumed only via the A/B registers, so no same-cycle bypass is required.
- Reset mid-request: `mem_req` drops asynchronously and the request is abandoned. Memory must tolerate this.
- HALT: PC stays at (illegal instruction address + 4), and `retired` is frozen.

## Structure
- Package `mips_pkg` holds:
  - opcode and funct localparams;
  - the 4-bit state encoding above;
  - the 3-bit ALU control codes (add, sub, and, or, slt).
- One sub-module, `mips_regfile`: 2 read ports, 1 write port, $0 hardwired to 0, async reset.
- ALU decode and the FSM live in the core.

## Test plan
- addi $1,$0,5; addi $2,$0,7; add $3,$1,$2, with `mem_ready`=1 -> $3=12, `retired`=3, total 12 cycles after reset release.
- sw $3,0x10($0); lw $4,0x10($0) -> store observed with addr=0x10, wdata=12; then $4=12. lw takes 5 cycles.
- beq $1,$1,-1 at PC=0x20 -> PC returns to 0x20 every 3 cycles. With $1≠$2, beq falls through to 0x24.
- j 0x40 from PC 0x3C -> next fetch address = 0x100. Writes to $0 leave $0 reading 0.
- Random 0–3 cycle `mem_ready` stalls across the same program -> identical register results; request signals stay stable while stalled.
- Opcode 0x3F fetched at 0x08 -> `halted`=1, `state`=15, `mem_req` stays 0. Asserting `rst` mid-FETCH stall -> `mem_req` goes 0 immediately, PC=RESET_PC, `retired`=0.
